// File: rtl/ovi_pkg.sv
// ovi_pkg: shared types and seq_id field widths for the OVI load-data transmitter
// No ports. Defines the FSM state enum, the memory line size and the seq_id
// field widths, and supplies default OVI bus widths when the build does not.
`ifndef OVI_SBID_WIDTH
`define OVI_SBID_WIDTH 5
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 11
`endif
`ifndef OVI_MEMDATA_WIDTH
`define OVI_MEMDATA_WIDTH 512
`endif

package ovi_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_LINE, SEND, SYNC} state_t;
    localparam int LINE_BYTES = 64;
    localparam int SBID_W     = `OVI_SBID_WIDTH;
    localparam int ELCNT_W    = 7;
    localparam int ELOFF_W    = 6;
    localparam int ELID_W     = 11;
    localparam int VREG_W     = 5;
endpackage

// File: rtl/ovi_credit_cnt.sv
// ovi_credit_cnt: saturating OVI load-credit counter
// clk, rst : clock, async active-high reset (count returns to CREDITS)
// inc      : credit returned by the receiver
// dec      : credit consumed by an issued beat
// count    : credits currently held
module ovi_credit_cnt
    import ovi_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int W       = $clog2(CREDITS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);
    logic full;

    assign full = count == W'(CREDITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= W'(CREDITS);
        else if (inc && !dec && !full)
            count <= count + 1'b1;
        else if (dec && !inc && count != '0)
            count <= count - 1'b1;
    end

    // A return while already full would mean the receiver handed back more than it got.
    assert property (@(posedge clk) disable iff (rst) !(inc && !dec && full));
endmodule

// File: rtl/ovi_load_seq_tx.sv
// ovi_load_seq_tx: memory-side OVI load-data transmitter (unit-stride loads)
// start_*      : load descriptor handshake (start_ready high in IDLE)
// line_*       : 512-bit memory line handshake (line_ready high in WAIT_LINE)
// load_credit  : one-cycle credit return from the VPU
// load_*       : vpu_load_bus beat with seq_id fields, load_valid is a pulse
// sync_end     : memop completion pulse with memop_sb_id
// busy         : operation in progress
// Optional OVI_LOAD_PERF_EN adds perf_beats and perf_credit_stall counters.
module ovi_load_seq_tx
    import ovi_pkg::*;
#(
    parameter int CREDITS    = 4,
    parameter int VLEN_BYTES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [`OVI_SBID_WIDTH-1:0]    start_sb_id,
    input  logic [`OVI_VL_WIDTH-1:0]      start_vl,
    input  logic [1:0]                    start_sew,
    input  logic [ELOFF_W-1:0]            start_off,
    input  logic [VREG_W-1:0]             start_vd,
    input  logic                          line_valid,
    output logic                          line_ready,
    input  logic [`OVI_MEMDATA_WIDTH-1:0] line_data,
    input  logic                          load_credit,
    output logic                          load_valid,
    output logic [`OVI_MEMDATA_WIDTH-1:0] load_data,
    output logic [`OVI_SBID_WIDTH-1:0]    load_sb_id,
    output logic [ELCNT_W-1:0]            load_el_count,
    output logic [ELOFF_W-1:0]            load_el_off,
    output logic [ELID_W-1:0]             load_el_id,
    output logic [VREG_W-1:0]             load_v_reg,
    output logic [63:0]                   load_mask,
    output logic                          load_mask_valid,
    output logic                          sync_end,
    output logic [`OVI_SBID_WIDTH-1:0]    memop_sb_id,
    output logic [14:0]                   memop_vstart_vlfof,
    output logic                          busy
`ifdef OVI_LOAD_PERF_EN
    ,
    output logic [31:0]                   perf_beats,
    output logic [31:0]                   perf_credit_stall
`endif
);
    localparam int VLW  = `OVI_VL_WIDTH;
    localparam int CW   = $clog2(CREDITS + 1);
    localparam int POSW = ELID_W + 3;

    state_t                          state, state_n;
    logic [`OVI_SBID_WIDTH-1:0]      sb_id, sb_id_n;
    logic [VLW-1:0]                  rem, rem_n;
    logic [1:0]                      sew, sew_n;
    logic [ELOFF_W-1:0]              off, off_n;
    logic [VREG_W-1:0]               vd, vd_n;
    logic [ELID_W-1:0]               el_id, el_id_n;
    logic [`OVI_MEMDATA_WIDTH-1:0]   line, line_n;
    logic [CW-1:0]                   credits;
    logic                            issue;
    logic [POSW-1:0]                 pos;
    logic [6:0]                      room_line, room_vreg, cnt_lv, cnt;
    logic [8:0]                      adv;

    ovi_credit_cnt #(.CREDITS(CREDITS)) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (load_credit),
        .dec   (issue),
        .count (credits)
    );

    // pos is the byte offset of el_id within the destination register group;
    // a beat is cut at whichever comes first: end of line, end of register, end of vl.
    assign pos       = POSW'(el_id) << sew;
    assign room_line = (7'd64 - 7'(off)) >> sew;
    assign room_vreg = 7'(VLEN_BYTES - int'(pos % POSW'(VLEN_BYTES))) >> sew;
    assign cnt_lv    = room_line < room_vreg ? room_line : room_vreg;
    assign cnt       = rem < VLW'(cnt_lv) ? 7'(rem) : cnt_lv;
    assign adv       = 9'(cnt) << sew;
    assign issue     = state == SEND && credits != '0;

    assign start_ready        = state == IDLE;
    assign line_ready         = state == WAIT_LINE;
    assign busy               = state != IDLE;
    assign load_mask          = '0;
    assign load_mask_valid    = 1'b0;
    assign memop_vstart_vlfof = '0;
    // The held line only changes in WAIT_LINE, so it is stable for every beat cut from it.
    assign load_data          = line;

    always_comb begin
        state_n = state;
        sb_id_n = sb_id;
        rem_n   = rem;
        sew_n   = sew;
        off_n   = off;
        vd_n    = vd;
        el_id_n = el_id;
        line_n  = line;
        case (state)
            IDLE: if (start_valid) begin
                sb_id_n = start_sb_id;
                rem_n   = start_vl;
                sew_n   = start_sew;
                off_n   = start_off;
                vd_n    = start_vd;
                el_id_n = '0;
                state_n = start_vl != '0 ? WAIT_LINE : SYNC;
            end
            WAIT_LINE: if (line_valid) begin
                line_n  = line_data;
                state_n = SEND;
            end
            SEND: if (issue) begin
                rem_n   = rem - VLW'(cnt);
                el_id_n = el_id + ELID_W'(cnt);
                off_n   = off + adv[5:0];
                state_n = rem_n == '0 ? SYNC : off_n == '0 ? WAIT_LINE : SEND;
            end
            SYNC: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sb_id         <= '0;
            rem           <= '0;
            sew           <= '0;
            off           <= '0;
            vd            <= '0;
            el_id         <= '0;
            line          <= '0;
            load_valid    <= 1'b0;
            load_sb_id    <= '0;
            load_el_count <= '0;
            load_el_off   <= '0;
            load_el_id    <= '0;
            load_v_reg    <= '0;
            sync_end      <= 1'b0;
            memop_sb_id   <= '0;
        end else begin
            state         <= state_n;
            sb_id         <= sb_id_n;
            rem           <= rem_n;
            sew           <= sew_n;
            off           <= off_n;
            vd            <= vd_n;
            el_id         <= el_id_n;
            line          <= line_n;
            load_valid    <= issue;
            if (issue) begin
                load_sb_id    <= sb_id;
                load_el_count <= cnt;
                load_el_off   <= off;
                load_el_id    <= el_id;
                load_v_reg    <= vd + VREG_W'(pos / POSW'(VLEN_BYTES));
            end
            sync_end      <= state == SYNC;
            if (state == SYNC)
                memop_sb_id <= sb_id;
        end
    end

`ifdef OVI_LOAD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_beats        <= '0;
            perf_credit_stall <= '0;
        end else begin
            if (load_valid)
                perf_beats <= perf_beats + 1'b1;
            if (state == SEND && credits == '0)
                perf_credit_stall <= perf_credit_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ovi_load_seq_tx.sv
// tb_ovi_load_seq_tx: directed self-checking bench for ovi_load_seq_tx
module tb_ovi_load_seq_tx;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [4:0]   start_sb_id = '0;
    logic [10:0]  start_vl = '0;
    logic [1:0]   start_sew = '0;
    logic [5:0]   start_off = '0;
    logic [4:0]   start_vd = '0;
    logic         line_valid = 1'b0;
    logic         line_ready;
    logic [511:0] line_data = '0;
    logic         load_credit = 1'b0;
    logic         load_valid;
    logic [511:0] load_data;
    logic [4:0]   load_sb_id;
    logic [6:0]   load_el_count;
    logic [5:0]   load_el_off;
    logic [10:0]  load_el_id;
    logic [4:0]   load_v_reg;
    logic [63:0]  load_mask;
    logic         load_mask_valid;
    logic         sync_end;
    logic [4:0]   memop_sb_id;
    logic [14:0]  memop_vstart_vlfof;
    logic         busy;
`ifdef OVI_LOAD_PERF_EN
    logic [31:0]  perf_beats;
    logic [31:0]  perf_credit_stall;
`endif
    int checks = 0;
    int errors = 0;
    logic [511:0] d1, d2a, d2b, d3a, d3b, d4a, d4b, d5, e1, e2, e3;

    ovi_load_seq_tx #(.CREDITS(4), .VLEN_BYTES(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .start_valid        (start_valid),
        .start_ready        (start_ready),
        .start_sb_id        (start_sb_id),
        .start_vl           (start_vl),
        .start_sew          (start_sew),
        .start_off          (start_off),
        .start_vd           (start_vd),
        .line_valid         (line_valid),
        .line_ready         (line_ready),
        .line_data          (line_data),
        .load_credit        (load_credit),
        .load_valid         (load_valid),
        .load_data          (load_data),
        .load_sb_id         (load_sb_id),
        .load_el_count      (load_el_count),
        .load_el_off        (load_el_off),
        .load_el_id         (load_el_id),
        .load_v_reg         (load_v_reg),
        .load_mask          (load_mask),
        .load_mask_valid    (load_mask_valid),
        .sync_end           (sync_end),
        .memop_sb_id        (memop_sb_id),
        .memop_vstart_vlfof (memop_vstart_vlfof),
        .busy               (busy)
`ifdef OVI_LOAD_PERF_EN
        ,
        .perf_beats         (perf_beats),
        .perf_credit_stall  (perf_credit_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    function automatic logic [511:0] mk(int n);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(n) * 32'h0100_0193 + 32'(i);
        return r;
    endfunction

    task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [4:0] sb, logic [10:0] vl, logic [1:0] sew, logic [5:0] off, logic [4:0] vd);
        chk("start_ready", start_ready, 1);
        start_valid = 1'b1;
        start_sb_id = sb;
        start_vl = vl;
        start_sew = sew;
        start_off = off;
        start_vd = vd;
        tick();
        start_valid = 1'b0;
    endtask

    task automatic give_line(logic [511:0] d);
        int n = 0;
        line_valid = 1'b1;
        line_data = d;
        while (!line_ready && n < 50) begin
            tick();
            n++;
        end
        chk("line_wait_bound", n < 50, 1);
        tick();
        line_valid = 1'b0;
    endtask

    task automatic chk_beat(string tag, logic [6:0] c, logic [5:0] o, logic [10:0] id, logic [4:0] v, logic [4:0] sb, logic [511:0] d);
        chk({tag, "/valid"}, load_valid, 1);
        chk({tag, "/el_count"}, load_el_count, c);
        chk({tag, "/el_off"}, load_el_off, o);
        chk({tag, "/el_id"}, load_el_id, id);
        chk({tag, "/v_reg"}, load_v_reg, v);
        chk({tag, "/sb_id"}, load_sb_id, sb);
        chk({tag, "/data"}, load_data, d);
    endtask

    task automatic chk_sync(string tag, logic [4:0] sb);
        chk({tag, "/sync_end"}, sync_end, 1);
        chk({tag, "/memop_sb_id"}, memop_sb_id, sb);
        chk({tag, "/no_beat"}, load_valid, 0);
        tick();
        chk({tag, "/sync_pulse"}, sync_end, 0);
        chk({tag, "/idle"}, busy, 0);
    endtask

    initial begin
        int seen;
        d1 = mk(1); d2a = mk(2); d2b = mk(3); d3a = mk(4); d3b = mk(5);
        d4a = mk(6); d4b = mk(7); d5 = mk(8); e1 = mk(9); e2 = mk(10); e3 = mk(11);
        tick();
        tick();
        chk("rst/load_valid", load_valid, 0);
        chk("rst/sync_end", sync_end, 0);
        chk("rst/busy", busy, 0);
        chk("rst/line_ready", line_ready, 0);
        chk("rst/load_data", load_data, 0);
        chk("rst/el_count", load_el_count, 0);
        chk("rst/start_ready", start_ready, 1);
        rst = 1'b0;
        tick();
        // one full-register beat, line handshake to beat is two cycles
        do_start(5, 16, 2, 0, 3);
        give_line(d1);
        chk("t1/latency_early", load_valid, 0);
        tick();
        chk_beat("t1", 16, 0, 0, 3, 5, d1);
        chk("t1/mask", load_mask, 0);
        chk("t1/mask_valid", load_mask_valid, 0);
        chk("t1/vstart", memop_vstart_vlfof, 0);
        tick();
        chk_sync("t1", 5);
        load_credit = 1'b1;
        tick();
        load_credit = 1'b0;
        // offset start, second line split across a register boundary
        do_start(6, 10, 3, 32, 1);
        give_line(d2a);
        tick();
        chk_beat("t2b1", 4, 32, 0, 1, 6, d2a);
        give_line(d2b);
        tick();
        chk_beat("t2b2", 4, 0, 4, 1, 6, d2b);
        chk("t2/no_third_line", line_ready, 0);
        tick();
        chk_beat("t2b3", 2, 32, 8, 2, 6, d2b);
        chk("t2/no_line_b3", line_ready, 0);
        tick();
        chk("t2/no_line_sync", line_ready, 0);
        chk_sync("t2", 6);
        // one credit left: second beat waits for a return
        do_start(9, 32, 2, 0, 7);
        give_line(d3a);
        tick();
        chk_beat("t3b1", 16, 0, 0, 7, 9, d3a);
        give_line(d3b);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_valid) seen++;
        end
        chk("t3/stalled", seen, 0);
        chk("t3/busy", busy, 1);
        load_credit = 1'b1;
        tick();
        load_credit = 1'b0;
        chk("t3/not_yet", load_valid, 0);
        tick();
        chk_beat("t3b2", 16, 0, 16, 8, 9, d3b);
        tick();
        chk_sync("t3", 9);
        // single credit recycled in every issue cycle gives back-to-back beats
        load_credit = 1'b1;
        tick();
        load_credit = 1'b0;
        do_start(2, 10, 3, 32, 1);
        line_valid = 1'b1;
        line_data = d4a;
        tick();
        load_credit = 1'b1;
        tick();
        chk_beat("t4b1", 4, 32, 0, 1, 2, d4a);
        load_credit = 1'b0;
        line_data = d4b;
        tick();
        line_valid = 1'b0;
        load_credit = 1'b1;
        tick();
        chk_beat("t4b2", 4, 0, 4, 1, 2, d4b);
        tick();
        chk_beat("t4b3", 2, 32, 8, 2, 2, d4b);
        load_credit = 1'b0;
        tick();
        chk_sync("t4", 2);
        // vl = 0 completes without touching memory
        line_valid = 1'b1;
        line_data = d5;
        do_start(17, 0, 1, 0, 0);
        chk("t5/no_line_ready", line_ready, 0);
        chk("t5/early", sync_end, 0);
        tick();
        chk("t5/no_line_ready2", line_ready, 0);
        chk_sync("t5", 17);
        line_valid = 1'b0;
        // reset between beats abandons the op and refills credits
        do_start(11, 10, 3, 32, 4);
        give_line(d2a);
        tick();
        chk("t6/beat_before_rst", load_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6/rst_valid", load_valid, 0);
        chk("t6/rst_busy", busy, 0);
        chk("t6/rst_el_count", load_el_count, 0);
        chk("t6/rst_data", load_data, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6/no_sync", sync_end, 0);
        do_start(12, 16, 3, 32, 4);
        give_line(e1);
        tick();
        chk_beat("t6b1", 4, 32, 0, 4, 12, e1);
        give_line(e2);
        tick();
        chk_beat("t6b2", 4, 0, 4, 4, 12, e2);
        tick();
        chk_beat("t6b3", 4, 32, 8, 5, 12, e2);
        give_line(e3);
        tick();
        chk_beat("t6b4", 4, 0, 12, 5, 12, e3);
        tick();
        chk_sync("t6", 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
